// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: streams W operand bits LSB-first through an external 1-bit full adder.
// Latency: start sampled at edge 0, busy cycles 1..W, done pulse in cycle W+1.
// Backpressure: none; start is ignored while busy, clr aborts to IDLE from any state.
module serial_add_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         clr,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Ci,
    output logic         bit_a,
    output logic         bit_b,
    output logic         bit_ci,
    input  logic         bit_s,
    input  logic         bit_co,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] S,
    output logic         Co
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t        state;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-2:0]  r_sh;
    logic          carry;
    logic [CW-1:0] cnt;
    logic [W-1:0]  r_nxt;

    // Result register holds W-1 bits; the final sum bit arrives on the completing edge.
    assign r_nxt  = {bit_s, r_sh};

    assign bit_a  = (state == ST_RUN) & a_sh[0];
    assign bit_b  = (state == ST_RUN) & b_sh[0];
    assign bit_ci = (state == ST_RUN) & carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            S     <= '0;
            Co    <= 1'b0;
        end else if (clr) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        carry <= Ci;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= bit_co;
                    r_sh  <= r_nxt[W-1:1];
                    if (cnt == LAST) begin
                        S     <= r_nxt;
                        Co    <= bit_co;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: W, default 8, operand/result width in bits (W >= 2).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request a new addition; sampled only in IDLE or DONE.
REQ-005 clr  input  1  synchronous abort; returns to IDLE.
REQ-006 A  input  W  operand A; captured on accepted start.
REQ-007 B  input  W  operand B; captured on accepted start.
REQ-008 Ci  input  1  carry-in; captured on accepted start.
REQ-009 bit_a  output  1  operand bit to the shared 1-bit full adder.
REQ-010 bit_b  output  1  operand bit to the shared 1-bit full adder.
REQ-011 bit_ci  output  1  carry bit to the shared 1-bit full adder.
REQ-012 bit_s  input  1  sum from the shared full adder, combinational from bit_a/bit_b/bit_ci.
REQ-013 bit_co  input  1  carry-out from the shared full adder, combinational.
REQ-014 busy  output  1  high while in RUN.
REQ-015 done  output  1  one-cycle pulse when a result becomes valid.
REQ-016 S  output  W  registered sum of the last completed addition.
REQ-017 Co  output  1  registered carry-out of the last completed addition.

Function
REQ-018 FSM states: IDLE, RUN, DONE; encoding is implementation choice.
REQ-019 IDLE/DONE with start=1 and clr=0: capture A, B into shift registers, Ci into carry register, clear bit counter, go to RUN.
REQ-020 RUN: drive bit_a = A shift LSB, bit_b = B shift LSB, bit_ci = carry register, all combinationally from registers.
REQ-021 RUN, each edge: shift bit_s into result shift register at MSB, shift operands right, carry <= bit_co, counter += 1.
REQ-022 RUN, W bits processed (counter = W-1 at edge): copy result register (including the final bit_s) to S, bit_co to Co, go to DONE.
REQ-023 Latency: start sampled at edge 0 -> busy high for cycles 1..W -> done high exactly in cycle W+1.
REQ-024 DONE lasts one cycle; without start it returns to IDLE; with start it goes to RUN (back-to-back, no idle cycle).
REQ-025 start in RUN is ignored; A/B/Ci changes in RUN have no effect.
REQ-026 clr=1 in any state: go to IDLE next edge; S, Co unchanged; no done pulse; clr has priority over start.
REQ-027 S and Co change only on RUN->DONE transition; they hold otherwise.
REQ-028 bit_a, bit_b, bit_ci are 0 outside RUN.
REQ-029 Arithmetic: {Co,S} = A + B + Ci modulo 2^(W+1), unsigned.
REQ-030 Counter width ceil(log2(W)); no wrap beyond W-1 in RUN.

Reset
REQ-031 rst_n low: state IDLE, S=0, Co=0, busy=0, done=0, bit_* = 0, internal registers 0, immediately without clock.
REQ-032 rst_n low mid-RUN aborts the operation; no done pulse follows release.
REQ-033 First start is accepted on the first rising edge with rst_n high.

Verification (W=8)
REQ-034 A=0x5A, B=0x3C, Ci=0, start one cycle -> done in cycle 9, S=0x96, Co=0; busy high cycles 1..8.
REQ-035 A=0xFF, B=0x01, Ci=0 -> S=0x00, Co=1; A=0xFF, B=0xFF, Ci=1 -> S=0xFF, Co=1.
REQ-036 start pulsed again in cycle 4 of RUN with different operands -> ignored; first result delivered unchanged in cycle 9.
REQ-037 start held high through DONE with new operands 0x01+0x01 -> RUN re-entered without idle cycle; second done 9 cycles after first, S=0x02, Co=0.
REQ-038 clr in cycle 5 of RUN -> IDLE next cycle, no done, S/Co keep previous values; rst_n low mid-RUN -> all outputs 0 asynchronously.
REQ-039 Random A, B, Ci (>=1000 runs) with behavioural full adder on bit_* -> {Co,S} matches A+B+Ci every run.
